// File: rtl/fsub8bit_serial.sv
// Slice-serial subtractor: diff = a - b - bin, one SLICE-bit slice per clock, LSB first.
// The inter-slice borrow lives in a register, so only one SLICE-wide adder exists.
module fsub8bit_serial #(
    parameter int WIDTH = 8,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int N    = WIDTH / SLICE;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [WIDTH-1:0]  partial_reg;
    logic              borrow_reg;
    logic [IDXW-1:0]   idx_reg;

    logic [SLICE-1:0]  a_sl [N];
    logic [SLICE-1:0]  b_sl [N];
    logic [SLICE-1:0]  a_s;
    logic [SLICE-1:0]  b_s;
    logic [SLICE:0]    slice_sum;
    logic              borrow_next;
    logic [WIDTH-1:0]  partial_next;
    logic              ovf_next;
    logic              last_slice;

    // Split the captured operands into slices so the active one can be muxed by index.
    for (genvar gi = 0; gi < N; gi++) begin : g_slices
        assign a_sl[gi] = a_reg[gi*SLICE +: SLICE];
        assign b_sl[gi] = b_reg[gi*SLICE +: SLICE];
        assign partial_next[gi*SLICE +: SLICE] =
            (idx_reg == IDXW'(gi)) ? slice_sum[SLICE-1:0] : partial_reg[gi*SLICE +: SLICE];
    end

    assign a_s = a_sl[idx_reg];
    assign b_s = b_sl[idx_reg];

    // Subtraction as a + ~b + carry_in, where carry_in is the inverted borrow.
    assign slice_sum   = {1'b0, a_s} + {1'b0, ~b_s} + {{SLICE{1'b0}}, ~borrow_reg};
    assign borrow_next = ~slice_sum[SLICE];

    assign ovf_next   = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                        (partial_next[WIDTH-1] != a_reg[WIDTH-1]);
    assign last_slice = (idx_reg == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            partial_reg <= '0;
            borrow_reg  <= 1'b0;
            idx_reg     <= '0;
            diff        <= '0;
            bout        <= 1'b0;
            ovf         <= 1'b0;
            zero        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg       <= a;
                        b_reg       <= b;
                        borrow_reg  <= bin;
                        idx_reg     <= '0;
                        partial_reg <= '0;
                        busy        <= 1'b1;
                        state_reg   <= CALC;
                    end
                end
                CALC: begin
                    partial_reg <= partial_next;
                    borrow_reg  <= borrow_next;
                    idx_reg     <= idx_reg + IDXW'(1);
                    if (last_slice) begin
                        // Results publish atomically on the edge that retires the top slice.
                        diff      <= partial_next;
                        bout      <= borrow_next;
                        ovf       <= ovf_next;
                        zero      <= (partial_next == '0);
                        idx_reg   <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg       <= a;
                        b_reg       <= b;
                        borrow_reg  <= bin;
                        idx_reg     <= '0;
                        partial_reg <= '0;
                        busy        <= 1'b1;
                        state_reg   <= CALC;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsub8bit_serial.sv
// Directed and randomized checks of fsub8bit_serial against an integer-arithmetic model.
module tb_fsub8bit_serial;

    localparam int NSL = 2;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    logic       zero;
    logic       busy;
    logic       done;

    int compared   = 0;
    int mismatched = 0;

    logic [10:0] prev_res;

    fsub8bit_serial #(.WIDTH(8), .SLICE(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf),
        .zero  (zero),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {zero, ovf, bout, diff[7:0]} from plain signed/unsigned arithmetic.
    function automatic logic [10:0] model(input logic [7:0] x, input logic [7:0] y, input logic c);
        int          u;
        int          s;
        logic [7:0]  d;
        logic        bo;
        logic        ov;
        u  = int'(x) - int'(y) - int'(c);
        s  = int'($signed(x)) - int'($signed(y)) - int'(c);
        d  = u[7:0];
        bo = (u < 0);
        ov = (s > 127) || (s < -128);
        return {(d == 8'h00), ov, bo, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic [10:0] exp);
        chk({tag, ".diff"}, 32'(diff), 32'(exp[7:0]));
        chk({tag, ".bout"}, 32'(bout), 32'(exp[8]));
        chk({tag, ".ovf"},  32'(ovf),  32'(exp[9]));
        chk({tag, ".zero"}, 32'(zero), 32'(exp[10]));
    endtask

    // One isolated operation from IDLE, checking the full handshake timeline.
    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tbv, input logic tc);
        logic [10:0] exp;
        exp = model(ta, tbv, tc);
        @(negedge clk);
        start = 1'b1; a = ta; b = tbv; bin = tc;
        @(negedge clk);
        start = 1'b0; a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        chk({tag, ".busy1"}, 32'(busy), 32'd1);
        chk({tag, ".hold1"}, 32'(diff), 32'(prev_res[7:0]));
        @(negedge clk);
        chk({tag, ".busy2"}, 32'(busy), 32'd1);
        chk({tag, ".done2"}, 32'(done), 32'd0);
        @(negedge clk);
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".busy3"}, 32'(busy), 32'd0);
        chk_res(tag, exp);
        prev_res = exp;
        @(negedge clk);
        chk({tag, ".pulse"}, 32'(done), 32'd0);
        chk({tag, ".hold2"}, 32'(diff), 32'(exp[7:0]));
    endtask

    initial begin
        logic [10:0] pend [$];
        logic [10:0] exp;
        int          cnt;
        logic        exp_done;
        logic        st;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic        rc;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        prev_res = '0;
        #1;
        chk("rst.diff", 32'(diff), 32'd0);
        chk("rst.bout", 32'(bout), 32'd0);
        chk("rst.ovf",  32'(ovf),  32'd0);
        chk("rst.zero", 32'(zero), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op("t1",   8'h05, 8'h03, 1'b0);
        run_op("t2a",  8'h00, 8'h01, 1'b0);
        run_op("t2b",  8'h10, 8'h01, 1'b1);
        run_op("t3a",  8'h80, 8'h01, 1'b0);
        run_op("t3b",  8'h7F, 8'hFF, 1'b0);
        run_op("t4a",  8'h37, 8'h37, 1'b0);
        run_op("t4b",  8'h37, 8'h37, 1'b1);
        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("rnd%0d", i), 8'($urandom), 8'($urandom), 1'($urandom));
        end

        // Back-to-back and random start: model tracks slice cycles remaining.
        cnt = 0;
        for (int k = 0; k < 48; k++) begin
            if (k < 15)      st = 1'b1;
            else if (k < 44) st = 1'($urandom_range(0, 1));
            else             st = 1'b0;
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            start = st; a = ra; b = rb; bin = rc;
            exp_done = 1'b0;
            if (cnt == 0) begin
                if (st) begin
                    pend.push_back(model(ra, rb, rc));
                    cnt = NSL;
                end
            end else begin
                cnt--;
                if (cnt == 0) exp_done = 1'b1;
            end
            @(negedge clk);
            chk($sformatf("bb%0d.done", k), 32'(done), 32'(exp_done));
            chk($sformatf("bb%0d.busy", k), 32'(busy), 32'(cnt > 0));
            if (exp_done && pend.size() > 0) begin
                exp = pend.pop_front();
                chk_res($sformatf("bb%0d", k), exp);
                prev_res = exp;
            end
        end
        start = 1'b0;

        // Abort mid-operation with reset.
        @(negedge clk);
        start = 1'b1; a = 8'h55; b = 8'h22; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("ab.busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ab.diff", 32'(diff), 32'd0);
        chk("ab.bout", 32'(bout), 32'd0);
        chk("ab.ovf",  32'(ovf),  32'd0);
        chk("ab.zero", 32'(zero), 32'd0);
        chk("ab.busy0", 32'(busy), 32'd0);
        chk("ab.done0", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        prev_res = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("ab.nodone%0d", k), 32'(done), 32'd0);
        end
        run_op("t6", 8'h55, 8'h22, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fsub8bit_serial.md
Name: fsub8bit_serial

Overview:
Multi-cycle subtractor, the inverse companion of the team's 8-bit ripple-carry adder. Computes diff = a - b - bin one 4-bit slice per clock, LSB slice first. The slice borrow is registered between cycles, so one 4-bit datapath is reused. A start/busy/done handshake lets a controller issue operations back-to-back.

Parameters:
WIDTH, 8, operand/result width in bits; must be an integer multiple of SLICE
SLICE, 4, bits processed per cycle; N = WIDTH/SLICE slice cycles per operation

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE or DONE
a  input  WIDTH  minuend; captured on the accepting edge
b  input  WIDTH  subtrahend; captured on the accepting edge
bin  input  1  borrow-in; captured on the accepting edge
diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH
bout  output  1  borrow-out: 1 when unsigned a < b + bin
ovf  output  1  two's-complement signed overflow of the subtraction
zero  output  1  1 when diff == 0
busy  output  1  high while slice cycles are in progress
done  output  1  one-cycle pulse marking that diff/bout/ovf/zero have just updated

Behaviour:
- Reset (async, rst=1): state=IDLE; diff=0, bout=0, ovf=0, zero=0, busy=0, done=0; slice index=0; internal borrow=0; operand registers cleared.
- States:
  - IDLE: start=1 -> capture a, b, bin; slice idx=0; go to CALC.
  - CALC: each edge computes slice idx:
    - Nibble result = a_s + ~b_s + ~borrow, with borrow initialised to bin.
    - Store the result into an internal partial register; next borrow = ~carry-out of that slice.
    - idx increments; on the edge that processes slice N-1, go to DONE.
  - DONE: lasts exactly one cycle.
    - start=1 -> capture new operands, go to CALC (back-to-back issue).
    - start=0 -> go to IDLE.
- The edge leaving CALC atomically loads diff, bout, ovf, zero from the partial register and final borrow.
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
  - diff/bout/ovf/zero change only on that edge and otherwise hold their last values.
- busy = (state == CALC); done = (state == DONE). Both are registered state decodes, with no combinational path from start.
- Latency: start accepted at edge E0 -> results valid and done=1 after edge E0+N, i.e. E0+2 for the default configuration.
- Throughput with start held high: one result every N+1 cycles.
- start while busy is ignored. Operands are registered, so a/b/bin may change freely after the accepting edge.
- rst asserted mid-operation: abort immediately to the reset values; no done pulse for the aborted operation.
- bin=1 with a=b gives diff = all-ones and bout=1.
- Borrow propagates across slice boundaries through the registered borrow only; no WIDTH-wide subtractor is permitted.

Test Plan:
1. Reset, then start with a=0x05, b=0x03, bin=0 -> after 2 edges: done=1, diff=0x02, bout=0, ovf=0, zero=0; busy high for exactly 2 cycles.
2. a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0. Then a=0x10, b=0x01, bin=1 -> diff=0x0E, bout=0; exercises borrow across the nibble boundary.
3. a=0x80, b=0x01 -> diff=0x7F, ovf=1, bout=0. Then a=0x7F, b=0xFF -> diff=0x80, ovf=1, bout=1.
4. a=0x37, b=0x37, bin=0 -> diff=0x00, zero=1. Same operands with bin=1 -> diff=0xFF, bout=1, zero=0.
5. Hold start=1 continuously and change operands every cycle -> done pulses every 3 cycles; each result matches the operands present on its accepting edge; start pulses during busy produce no extra operation.
6. Start a=0x55, b=0x22, then assert rst during the second CALC cycle -> all outputs 0 immediately, no done pulse. Release rst and issue a=0x55, b=0x22 -> diff=0x33.
